// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between requesters, the round-robin arbiter and the FIFO.
//   req/req_data : requester words, slice i = req_data[i*WIDTH +: WIDTH]
//   ack          : one-hot accept strobe back to the requesters
//   full         : FIFO full flag
//   write_en/write_data : FIFO write port
//   grant_valid/grant_id : current grant holder
// master = arbiter side, slave = requester/FIFO side.
interface fifo_write_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       ack;
    logic                   full;
    logic                   write_en;
    logic [WIDTH-1:0]       write_data;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_id;

    modport master (
        input  req, req_data, full,
        output ack, write_en, write_data, grant_valid, grant_id
    );

    modport slave (
        output req, req_data, full,
        input  ack, write_en, write_data, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among N_REQ requesters.
// Grants one requester for a burst of up to MAX_BURST words, stalls on full,
// and hands off to the next requester with no bubble cycle.
//   wr_clk  : write-domain clock
//   reset_n : asynchronous active-low reset
//   bus     : fifo_write_arbiter_if.master (requests, FIFO write port, grant)
module fifo_write_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  wr_clk,
    input  logic                  reset_n,
    fifo_write_arbiter_if.master  bus
);
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           st_q, st_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             cur_req;
    logic             wr_c;
    logic [ID_W-1:0]  gid_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] slice_c;

    logic [N_REQ-1:0] arb_mask;
    logic [ID_W-1:0]  arb_start;
    logic [ID_W-1:0]  arb_sel;
    logic             arb_found;

    logic [N_REQ-1:0] ack_c;
    logic             release_c;

    // Per-cycle view of the current grant holder.
    always_comb begin
        cur_req  = bus.req[gid_q];
        wr_c     = (st_q == GRANT) && cur_req && !bus.full;
        gid_next = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + ID_W'(1);
        cnt_inc  = cnt_q + CNT_W'(1);
        slice_c  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ID_W'(i) == gid_q) begin
                slice_c = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin search; on release it starts after the holder, and a
    // withdrawn holder is masked so it cannot win its own handoff.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] idx_w;
        arb_start = (st_q == GRANT) ? gid_next : ptr_q;
        arb_mask  = bus.req;
        if ((st_q == GRANT) && !cur_req) begin
            arb_mask[gid_q] = 1'b0;
        end
        arb_found = 1'b0;
        arb_sel   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(arb_start) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = ID_W'(idx);
            if (!arb_found && arb_mask[idx_w]) begin
                arb_found = 1'b1;
                arb_sel   = idx_w;
            end
        end
    end

    // Next-state logic and write-port outputs.
    always_comb begin
        st_d      = st_q;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ack_c     = '0;
        release_c = 1'b0;

        if (st_q == IDLE) begin
            if (arb_found) begin
                st_d  = GRANT;
                gid_d = arb_sel;
                cnt_d = '0;
            end
        end else begin
            ack_c[gid_q] = wr_c;
            release_c    = !cur_req || (wr_c && (cnt_inc == CNT_W'(MAX_BURST)));
            if (wr_c) begin
                cnt_d = cnt_inc;
            end
            if (release_c) begin
                ptr_d = gid_next;
                cnt_d = '0;
                if (arb_found) begin
                    gid_d = arb_sel;
                end else begin
                    st_d = IDLE;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= IDLE;
            gid_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            gid_q <= gid_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.write_en    = wr_c;
    assign bus.ack         = ack_c;
    assign bus.write_data  = wr_c ? slice_c : '0;
    assign bus.grant_valid = (st_q == GRANT);
    assign bus.grant_id    = gid_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_fifo_write_arbiter;
    logic wr_clk;
    logic reset_n;
    int   n_vec;
    int   n_err;
    int   d [4];

    fifo_write_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

    fifo_write_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) u_dut (
        .wr_clk  (wr_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic we, input logic [3:0] ak,
                           input logic gv, input logic [1:0] gid, input logic [7:0] wd);
        chk({tag, ".write_en"},    32'(bus.write_en),    32'(we));
        chk({tag, ".ack"},         32'(bus.ack),         32'(ak));
        chk({tag, ".grant_valid"}, 32'(bus.grant_valid), 32'(gv));
        chk({tag, ".grant_id"},    32'(bus.grant_id),    32'(gid));
        chk({tag, ".write_data"},  32'(bus.write_data),  32'(wd));
        chk({tag, ".ack_onehot"},  32'($onehot0(bus.ack)), 32'd1);
    endtask

    task automatic set_slice(input int i, input logic [7:0] v);
        bus.req_data[i*8 +: 8] = v;
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        reset_n      = 1'b0;
        bus.req      = '0;
        bus.full     = 1'b0;
        bus.req_data = '0;
        repeat (2) @(negedge wr_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        bus.req      = '0;
        bus.full     = 1'b0;
        bus.req_data = '0;

        // Reset / idle, then single request from requester 2.
        repeat (2) @(negedge wr_clk);
        #1 exp_out("rst", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        reset_n = 1'b1;
        bus.req = 4'b0100;
        set_slice(2, 8'hA0);
        #1 exp_out("idle_req", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("first_grant", 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA0);
        @(negedge wr_clk);
        bus.req = 4'b0000;
        #1 exp_out("drop2", 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("back_idle", 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00);

        // Burst limit with a sole requester: back-to-back re-grants.
        @(negedge wr_clk);
        bus.req = 4'b0010;
        set_slice(1, 8'h11);
        #1 exp_out("burst_idle", 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00);
        for (int k = 0; k < 9; k++) begin
            @(negedge wr_clk);
            set_slice(1, 8'(8'h11 + k));
            #1 exp_out($sformatf("burst%0d", k), 1'b1, 4'b0010, 1'b1, 2'd1, 8'(8'h11 + k));
        end
        @(negedge wr_clk);
        bus.req = 4'b0000;
        #1 exp_out("burst_drop", 1'b0, 4'b0000, 1'b1, 2'd1, 8'h00);

        // Round-robin with all four requesting.
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = i * 16;
        @(negedge wr_clk);
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) set_slice(i, 8'(d[i]));
        #1 exp_out("rr_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            @(negedge wr_clk);
            for (int i = 0; i < 4; i++) set_slice(i, 8'(d[i]));
            #1 exp_out($sformatf("rr%0d", c), 1'b1, 4'(1 << ((c / 4) % 4)), 1'b1,
                       2'((c / 4) % 4), 8'(((c / 4) % 4) * 16 + (c / 16) * 4 + c % 4));
            for (int i = 0; i < 4; i++) if (bus.ack[i]) d[i]++;
        end
        @(negedge wr_clk);
        bus.req = 4'b0000;
        #1 exp_out("rr_drop", 1'b0, 4'b0000, 1'b1, 2'd1, 8'h00);

        // Backpressure mid-burst of requester 2.
        do_reset();
        @(negedge wr_clk);
        bus.req = 4'b0100;
        set_slice(2, 8'h20);
        #1 exp_out("bp_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("bp_w0", 1'b1, 4'b0100, 1'b1, 2'd2, 8'h20);
        @(negedge wr_clk);
        set_slice(2, 8'h21);
        #1 exp_out("bp_w1", 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21);
        @(negedge wr_clk);
        set_slice(2, 8'h22);
        bus.full = 1'b1;
        #1 exp_out("bp_full0", 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00);
        for (int k = 1; k < 5; k++) begin
            @(negedge wr_clk);
            #1 exp_out($sformatf("bp_full%0d", k), 1'b0, 4'b0000, 1'b1, 2'd2, 8'h00);
        end
        @(negedge wr_clk);
        bus.full = 1'b0;
        #1 exp_out("bp_w2", 1'b1, 4'b0100, 1'b1, 2'd2, 8'h22);
        @(negedge wr_clk);
        set_slice(2, 8'h23);
        set_slice(3, 8'h30);
        bus.req = 4'b1100;
        #1 exp_out("bp_w3", 1'b1, 4'b0100, 1'b1, 2'd2, 8'h23);
        @(negedge wr_clk);
        #1 exp_out("bp_handoff", 1'b1, 4'b1000, 1'b1, 2'd3, 8'h30);
        @(negedge wr_clk);
        bus.req = 4'b0000;
        #1 exp_out("bp_drop", 1'b0, 4'b0000, 1'b1, 2'd3, 8'h00);

        // Early release: requester 3 withdraws after one word.
        do_reset();
        @(negedge wr_clk);
        bus.req = 4'b1000;
        set_slice(3, 8'h3A);
        #1 exp_out("er_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("er_w3", 1'b1, 4'b1000, 1'b1, 2'd3, 8'h3A);
        @(negedge wr_clk);
        bus.req = 4'b0001;
        set_slice(0, 8'h0B);
        #1 exp_out("er_dropcyc", 1'b0, 4'b0000, 1'b1, 2'd3, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("er_w0", 1'b1, 4'b0001, 1'b1, 2'd0, 8'h0B);
        @(negedge wr_clk);
        bus.req = 4'b0000;
        #1 exp_out("er_drop0", 1'b0, 4'b0000, 1'b1, 2'd0, 8'h00);

        // Asynchronous reset mid-burst of requester 1 (ptr moved to 1 first).
        do_reset();
        @(negedge wr_clk);
        bus.req = 4'b0001;
        set_slice(0, 8'h01);
        #1 exp_out("ar_idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("ar_w0", 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);
        @(negedge wr_clk);
        bus.req = 4'b0010;
        set_slice(1, 8'h10);
        #1 exp_out("ar_drop0", 1'b0, 4'b0000, 1'b1, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("ar_w1a", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h10);
        @(negedge wr_clk);
        set_slice(1, 8'h11);
        #1 exp_out("ar_w1b", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
        #1 reset_n = 1'b0;
        #1 exp_out("ar_async", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        bus.req = 4'b0011;
        set_slice(0, 8'h02);
        #1 exp_out("ar_held", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        reset_n = 1'b1;
        #1 exp_out("ar_rel", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(negedge wr_clk);
        #1 exp_out("ar_restart", 1'b1, 4'b0001, 1'b1, 2'd0, 8'h02);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
